// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: turns single-cycle user write/read commands into
// complete bus transactions. The write and read engines are independent,
// so one write and one read can be in flight at the same time.
// DATA_WIDTH is expected to be 32 or 64; the strobe is one bit per byte.
module axi4_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  // write address channel
  output logic                      m_AWVALID,
  output logic [2:0]                m_AWPROT,
  output logic [ADDR_WIDTH-1:0]     m_AWADDR,
  input  logic                      m_AWREADY,
  // write data channel
  output logic                      m_WVALID,
  output logic [DATA_WIDTH-1:0]     m_WDATA,
  output logic [DATA_WIDTH/8-1:0]   m_WSTRB,
  input  logic                      m_WREADY,
  // write response channel
  input  logic                      m_BVALID,
  input  logic [1:0]                m_BRESP,
  output logic                      m_BREADY,
  // read address channel
  output logic                      m_ARVALID,
  output logic [2:0]                m_ARPROT,
  output logic [ADDR_WIDTH-1:0]     m_ARADDR,
  input  logic                      m_ARREADY,
  // read data channel
  input  logic                      m_RVALID,
  input  logic [DATA_WIDTH-1:0]     m_RDATA,
  input  logic [1:0]                m_RRESP,
  output logic                      m_RREADY,
  // user write command and status
  input  logic                      write_start,
  input  logic [ADDR_WIDTH-1:0]     write_addr,
  input  logic [DATA_WIDTH-1:0]     write_data,
  input  logic [DATA_WIDTH/8-1:0]   write_strb,
  output logic                      write_busy,
  output logic                      write_done,
  output logic [1:0]                write_resp,
  // user read command and status
  input  logic                      read_start,
  input  logic [ADDR_WIDTH-1:0]     read_addr,
  output logic                      read_busy,
  output logic                      read_done,
  output logic [DATA_WIDTH-1:0]     read_data,
  output logic [1:0]                read_resp
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP, W_DONE} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} r_state_t;

  w_state_t                  w_state_q, w_state_d;
  logic                      awvalid_q, awvalid_d;
  logic [ADDR_WIDTH-1:0]     awaddr_q, awaddr_d;
  logic                      wvalid_q, wvalid_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
  logic                      bready_q, bready_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic                      wbusy_q, wbusy_d;
  logic                      wdone_q, wdone_d;
  logic [1:0]                wresp_q, wresp_d;

  r_state_t                  r_state_q, r_state_d;
  logic                      arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0]     araddr_q, araddr_d;
  logic                      rready_q, rready_d;
  logic                      rbusy_q, rbusy_d;
  logic                      rdone_q, rdone_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;

  assign m_AWPROT   = 3'b000;
  assign m_ARPROT   = 3'b000;
  assign m_AWVALID  = awvalid_q;
  assign m_AWADDR   = awaddr_q;
  assign m_WVALID   = wvalid_q;
  assign m_WDATA    = wdata_q;
  assign m_WSTRB    = wstrb_q;
  assign m_BREADY   = bready_q;
  assign m_ARVALID  = arvalid_q;
  assign m_ARADDR   = araddr_q;
  assign m_RREADY   = rready_q;
  assign write_busy = wbusy_q;
  assign write_done = wdone_q;
  assign write_resp = wresp_q;
  assign read_busy  = rbusy_q;
  assign read_done  = rdone_q;
  assign read_data  = rdata_q;
  assign read_resp  = rresp_q;

  // Write engine next state: AW and W complete independently, B follows both.
  always_comb begin
    w_state_d = w_state_q;
    awvalid_d = awvalid_q;
    awaddr_d  = awaddr_q;
    wvalid_d  = wvalid_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bready_d  = bready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    wbusy_d   = wbusy_q;
    wdone_d   = 1'b0;
    wresp_d   = wresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (write_start) begin
          awaddr_d  = write_addr;
          wdata_d   = write_data;
          wstrb_d   = write_strb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          wbusy_d   = 1'b1;
          w_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        if (awvalid_q && m_AWREADY) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && m_WREADY) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (m_BVALID && bready_q) begin
          wresp_d   = m_BRESP;
          bready_d  = 1'b0;
          w_state_d = W_DONE;
        end
      end
      W_DONE: begin
        wdone_d   = 1'b1;
        wbusy_d   = 1'b0;
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write engine registers; reset abandons any transaction in progress.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      w_state_q <= W_IDLE;
      awvalid_q <= 1'b0;
      awaddr_q  <= '0;
      wvalid_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wbusy_q   <= 1'b0;
      wdone_q   <= 1'b0;
      wresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      awvalid_q <= awvalid_d;
      awaddr_q  <= awaddr_d;
      wvalid_q  <= wvalid_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bready_q  <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      wbusy_q   <= wbusy_d;
      wdone_q   <= wdone_d;
      wresp_q   <= wresp_d;
    end
  end

  // Read engine next state: AR handshake, then wait for R.
  always_comb begin
    r_state_d = r_state_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    rready_d  = rready_q;
    rbusy_d   = rbusy_q;
    rdone_d   = 1'b0;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (read_start) begin
          araddr_d  = read_addr;
          arvalid_d = 1'b1;
          rbusy_d   = 1'b1;
          r_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        if (arvalid_q && m_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (m_RVALID && rready_q) begin
          rdata_d   = m_RDATA;
          rresp_d   = m_RRESP;
          rready_d  = 1'b0;
          r_state_d = R_DONE;
        end
      end
      R_DONE: begin
        rdone_d   = 1'b1;
        rbusy_d   = 1'b0;
        r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read engine registers; reset abandons any transaction in progress.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state_q <= R_IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      rready_q  <= 1'b0;
      rbusy_q   <= 1'b0;
      rdone_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      r_state_q <= r_state_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      rready_q  <= rready_d;
      rbusy_q   <= rbusy_d;
      rdone_q   <= rdone_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Testbench for axi4_lite_master: a delay-programmable slave responder plus
// directed and randomized transactions checked against expected results.
module tb_axi4_lite_master;

  localparam int AW = 32;
  localparam int DW = 32;

  logic            iCLK, iRST;
  logic            m_AWVALID, m_AWREADY, m_WVALID, m_WREADY, m_BVALID, m_BREADY;
  logic            m_ARVALID, m_ARREADY, m_RVALID, m_RREADY;
  logic [2:0]      m_AWPROT, m_ARPROT;
  logic [AW-1:0]   m_AWADDR, m_ARADDR;
  logic [DW-1:0]   m_WDATA, m_RDATA;
  logic [DW/8-1:0] m_WSTRB;
  logic [1:0]      m_BRESP, m_RRESP;
  logic            write_start, read_start;
  logic [AW-1:0]   write_addr, read_addr;
  logic [DW-1:0]   write_data;
  logic [DW/8-1:0] write_strb;
  logic            write_busy, write_done, read_busy, read_done;
  logic [1:0]      write_resp, read_resp;
  logic [DW-1:0]   read_data;

  axi4_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .m_AWVALID(m_AWVALID), .m_AWPROT(m_AWPROT), .m_AWADDR(m_AWADDR), .m_AWREADY(m_AWREADY),
    .m_WVALID(m_WVALID), .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB), .m_WREADY(m_WREADY),
    .m_BVALID(m_BVALID), .m_BRESP(m_BRESP), .m_BREADY(m_BREADY),
    .m_ARVALID(m_ARVALID), .m_ARPROT(m_ARPROT), .m_ARADDR(m_ARADDR), .m_ARREADY(m_ARREADY),
    .m_RVALID(m_RVALID), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP), .m_RREADY(m_RREADY),
    .write_start(write_start), .write_addr(write_addr), .write_data(write_data),
    .write_strb(write_strb), .write_busy(write_busy), .write_done(write_done),
    .write_resp(write_resp), .read_start(read_start), .read_addr(read_addr),
    .read_busy(read_busy), .read_done(read_done), .read_data(read_data), .read_resp(read_resp)
  );

  // slave configuration, written only by the main sequence
  int            cfg_aw_delay = 0, cfg_w_delay = 0, cfg_b_delay = 0;
  int            cfg_ar_delay = 0, cfg_r_delay = 0;
  bit            cfg_early = 0;
  logic [1:0]    cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [DW-1:0] cfg_rdata = '0;

  // slave observations, written only by the responder
  int              aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0;
  int              aw_valid_cyc = 0, w_valid_cyc = 0, stab_err = 0;
  logic [AW-1:0]   last_awaddr = '0, last_araddr = '0;
  logic [DW-1:0]   last_wdata = '0;
  logic [DW/8-1:0] last_wstrb = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // Free-running clock.
  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Slave responder: decides READY/VALID on each falling edge for the next rising edge.
  initial begin
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit aw_got, w_got, b_pending, r_pending, b_drop, r_drop;
    bit p_awv, p_wv, p_arv, p_aw_hs, p_w_hs, p_ar_hs;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [DW-1:0] p_wdata;
    logic [DW/8-1:0] p_wstrb;
    m_AWREADY = 0; m_WREADY = 0; m_BVALID = 0; m_BRESP = 0;
    m_ARREADY = 0; m_RVALID = 0; m_RDATA = 0; m_RRESP = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    aw_got = 0; w_got = 0; b_pending = 0; r_pending = 0; b_drop = 0; r_drop = 0;
    p_awv = 0; p_wv = 0; p_arv = 0; p_aw_hs = 0; p_w_hs = 0; p_ar_hs = 0;
    p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_wstrb = '0;
    forever begin
      @(negedge iCLK);
      if (!iRST) begin
        m_AWREADY = 0; m_WREADY = 0; m_BVALID = 0; m_ARREADY = 0; m_RVALID = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; b_pending = 0; r_pending = 0; b_drop = 0; r_drop = 0;
        p_awv = 0; p_wv = 0; p_arv = 0;
      end else begin
        if (m_AWVALID && p_awv && !p_aw_hs && m_AWADDR !== p_awaddr) stab_err++;
        if (m_WVALID && p_wv && !p_w_hs && {m_WDATA, m_WSTRB} !== {p_wdata, p_wstrb}) stab_err++;
        if (m_ARVALID && p_arv && !p_ar_hs && m_ARADDR !== p_araddr) stab_err++;
        if (b_drop) begin m_BVALID = 0; b_drop = 0; end
        if (b_pending && !m_BVALID) begin
          if (b_cnt >= cfg_b_delay) begin m_BVALID = 1; m_BRESP = cfg_bresp; b_pending = 0; end
          else b_cnt++;
        end
        if (m_BVALID && m_BREADY) begin b_hs_n++; b_drop = 1; end
        if (r_drop) begin m_RVALID = 0; r_drop = 0; end
        if (r_pending && !m_RVALID) begin
          if (r_cnt >= cfg_r_delay) begin
            m_RVALID = 1; m_RDATA = cfg_rdata; m_RRESP = cfg_rresp; r_pending = 0;
          end else r_cnt++;
        end
        if (m_RVALID && m_RREADY) begin r_hs_n++; r_drop = 1; end
        p_aw_hs = 0; p_w_hs = 0; p_ar_hs = 0;
        if (m_AWVALID) begin
          aw_valid_cyc++;
          if (aw_cnt >= cfg_aw_delay) begin
            m_AWREADY = 1; aw_hs_n++; last_awaddr = m_AWADDR; aw_got = 1; aw_cnt = 0; p_aw_hs = 1;
          end else begin m_AWREADY = 0; aw_cnt++; end
        end else begin m_AWREADY = cfg_early; aw_cnt = 0; end
        if (m_WVALID) begin
          w_valid_cyc++;
          if (w_cnt >= cfg_w_delay) begin
            m_WREADY = 1; w_hs_n++; last_wdata = m_WDATA; last_wstrb = m_WSTRB;
            w_got = 1; w_cnt = 0; p_w_hs = 1;
          end else begin m_WREADY = 0; w_cnt++; end
        end else begin m_WREADY = cfg_early; w_cnt = 0; end
        if (aw_got && w_got) begin b_pending = 1; b_cnt = 0; aw_got = 0; w_got = 0; end
        if (m_ARVALID) begin
          if (ar_cnt >= cfg_ar_delay) begin
            m_ARREADY = 1; ar_hs_n++; last_araddr = m_ARADDR;
            r_pending = 1; r_cnt = 0; ar_cnt = 0; p_ar_hs = 1;
          end else begin m_ARREADY = 0; ar_cnt++; end
        end else begin m_ARREADY = cfg_early; ar_cnt = 0; end
        p_awv = m_AWVALID; p_awaddr = m_AWADDR;
        p_wv = m_WVALID; p_wdata = m_WDATA; p_wstrb = m_WSTRB;
        p_arv = m_ARVALID; p_araddr = m_ARADDR;
      end
    end
  end

  // One comparison: count it, and on mismatch count and report the failure.
  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; returns just after the rising edge that samples it.
  task automatic apply_stimulus(input bit do_w, input bit do_r, input logic [AW-1:0] waddr,
                                input logic [DW-1:0] wdata, input logic [DW/8-1:0] wstrb,
                                input logic [AW-1:0] raddr);
    @(negedge iCLK);
    write_start = do_w; write_addr = waddr; write_data = wdata; write_strb = wstrb;
    read_start = do_r; read_addr = raddr;
    @(posedge iCLK);
    #1;
    write_start = 0;
    read_start = 0;
  endtask

  // Watch done pulses on falling edges; latency counts falling edges after the start edge.
  task automatic wait_done(input bit want_w, input bit want_r, output int w_lat, output int r_lat,
                           output int w_cnt, output int r_cnt, output int busy_bad);
    int cyc;
    cyc = 0; w_lat = -1; r_lat = -1; w_cnt = 0; r_cnt = 0; busy_bad = 0;
    while (cyc < 100 && ((want_w && w_lat < 0) || (want_r && r_lat < 0))) begin
      @(negedge iCLK);
      cyc++;
      if (write_done) begin w_cnt++; if (w_lat < 0) w_lat = cyc; if (write_busy) busy_bad++; end
      if (read_done) begin r_cnt++; if (r_lat < 0) r_lat = cyc; if (read_busy) busy_bad++; end
    end
    repeat (4) begin
      @(negedge iCLK);
      if (write_done) w_cnt++;
      if (read_done) r_cnt++;
    end
  endtask

  // Main directed and randomized sequence.
  initial begin
    int wl, rl, wc, rc, bb, aw0, w0, b0, ar0, r0, cnt;
    bit dw, dr;
    logic [AW-1:0] ea, ra;
    logic [DW-1:0] ed;
    logic [DW/8-1:0] es;
    iRST = 0; write_start = 0; read_start = 0;
    write_addr = '0; write_data = '0; write_strb = '0; read_addr = '0;
    repeat (3) @(negedge iCLK);
    check_output("reset_valid_ready", 64'({m_AWVALID, m_WVALID, m_BREADY, m_ARVALID, m_RREADY}), 64'(0));
    check_output("reset_status", 64'({write_busy, write_done, read_busy, read_done, write_resp, read_resp}), 64'(0));
    check_output("reset_payload", 64'(m_AWADDR | m_ARADDR | m_WDATA | read_data | 32'(m_WSTRB)), 64'(0));
    check_output("prot_tied", 64'({m_AWPROT, m_ARPROT}), 64'(0));
    iRST = 1;

    $display("[TB] write, slave always ready");
    aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
    cfg_bresp = 2'b00;
    apply_stimulus(1, 0, 32'h10, 32'hDEADBEEF, 4'hF, '0);
    check_output("w1_busy", 64'(write_busy), 64'(1));
    wait_done(1, 0, wl, rl, wc, rc, bb);
    check_output("w1_latency", 64'(wl), 64'(4));
    check_output("w1_done_pulses", 64'(wc), 64'(1));
    check_output("w1_aw_hs", 64'(aw_hs_n - aw0), 64'(1));
    check_output("w1_w_hs", 64'(w_hs_n - w0), 64'(1));
    check_output("w1_awaddr", 64'(last_awaddr), 64'(32'h10));
    check_output("w1_wdata", 64'(last_wdata), 64'(32'hDEADBEEF));
    check_output("w1_wstrb", 64'(last_wstrb), 64'(4'hF));
    check_output("w1_resp", 64'(write_resp), 64'(0));
    check_output("w1_busy_clear", 64'(write_busy), 64'(0));

    $display("[TB] skewed write, AWREADY late");
    aw0 = aw_valid_cyc; w0 = w_valid_cyc; b0 = b_hs_n;
    cfg_aw_delay = 3; cfg_bresp = 2'b10;
    apply_stimulus(1, 0, 32'h44, 32'h12345678, 4'h3, '0);
    wait_done(1, 0, wl, rl, wc, rc, bb);
    check_output("w2_awvalid_cycles", 64'(aw_valid_cyc - aw0), 64'(4));
    check_output("w2_wvalid_cycles", 64'(w_valid_cyc - w0), 64'(1));
    check_output("w2_b_hs", 64'(b_hs_n - b0), 64'(1));
    check_output("w2_done_pulses", 64'(wc), 64'(1));
    check_output("w2_latency", 64'(wl), 64'(7));
    check_output("w2_resp_slverr", 64'(write_resp), 64'(2'b10));
    cfg_aw_delay = 0;

    $display("[TB] read with two wait cycles");
    cfg_r_delay = 2; cfg_rdata = 32'hCAFEF00D; cfg_rresp = 2'b10;
    apply_stimulus(0, 1, '0, '0, '0, 32'h20);
    check_output("r1_busy", 64'(read_busy), 64'(1));
    wait_done(0, 1, wl, rl, wc, rc, bb);
    check_output("r1_araddr", 64'(last_araddr), 64'(32'h20));
    check_output("r1_data", 64'(read_data), 64'(32'hCAFEF00D));
    check_output("r1_resp", 64'(read_resp), 64'(2'b10));
    check_output("r1_done_pulses", 64'(rc), 64'(1));
    check_output("r1_latency", 64'(rl), 64'(6));
    cfg_r_delay = 0;

    $display("[TB] concurrent write and read, extra write_start while busy");
    aw0 = aw_hs_n; ar0 = ar_hs_n;
    cfg_bresp = 2'b00; cfg_rdata = 32'h0BADF00D; cfg_rresp = 2'b00;
    apply_stimulus(1, 1, 32'h04, 32'hA5A5A5A5, 4'hC, 32'h08);
    @(negedge iCLK);
    write_start = 1; write_addr = 32'hFC; write_data = 32'h11111111;
    @(posedge iCLK);
    #1 write_start = 0;
    wait_done(1, 1, wl, rl, wc, rc, bb);
    check_output("c_write_pulses", 64'(wc), 64'(1));
    check_output("c_read_pulses", 64'(rc), 64'(1));
    check_output("c_aw_hs_once", 64'(aw_hs_n - aw0), 64'(1));
    check_output("c_ar_hs_once", 64'(ar_hs_n - ar0), 64'(1));
    check_output("c_awaddr", 64'(last_awaddr), 64'(32'h04));
    check_output("c_wdata", 64'(last_wdata), 64'(32'hA5A5A5A5));
    check_output("c_araddr", 64'(last_araddr), 64'(32'h08));
    check_output("c_rdata", 64'(read_data), 64'(32'h0BADF00D));
    check_output("c_busy_at_done", 64'(bb), 64'(0));

    $display("[TB] READY high before VALID, DECERR response");
    cfg_early = 1; cfg_bresp = 2'b11;
    repeat (2) @(negedge iCLK);
    aw0 = aw_hs_n;
    apply_stimulus(1, 0, 32'h80, 32'h0F0F0F0F, 4'h1, '0);
    wait_done(1, 0, wl, rl, wc, rc, bb);
    check_output("e_latency", 64'(wl), 64'(4));
    check_output("e_aw_hs", 64'(aw_hs_n - aw0), 64'(1));
    check_output("e_resp_decerr", 64'(write_resp), 64'(2'b11));
    cfg_early = 0;

    $display("[TB] reset while waiting for B");
    cfg_b_delay = 10; cfg_bresp = 2'b00;
    apply_stimulus(1, 0, 32'h30, 32'h33333333, 4'hF, '0);
    cnt = 0;
    while (!m_BREADY && cnt < 20) begin @(negedge iCLK); cnt++; end
    check_output("rst_reached_wresp", 64'({m_BREADY, m_BVALID}), 64'(2'b10));
    iRST = 0;
    #1;
    check_output("rst_mid_valid_ready", 64'({m_AWVALID, m_WVALID, m_BREADY, m_ARVALID, m_RREADY}), 64'(0));
    check_output("rst_mid_status", 64'({write_busy, write_done, write_resp}), 64'(0));
    check_output("rst_mid_payload", 64'(m_AWADDR | m_WDATA), 64'(0));
    cnt = 0;
    repeat (3) begin @(negedge iCLK); if (write_done) cnt++; end
    iRST = 1;
    repeat (3) begin @(negedge iCLK); if (write_done) cnt++; end
    check_output("rst_no_done", 64'(cnt), 64'(0));
    cfg_b_delay = 0; cfg_bresp = 2'b01;
    apply_stimulus(1, 0, 32'h34, 32'h44444444, 4'hF, '0);
    wait_done(1, 0, wl, rl, wc, rc, bb);
    check_output("post_rst_latency", 64'(wl), 64'(4));
    check_output("post_rst_wdata", 64'(last_wdata), 64'(32'h44444444));
    check_output("post_rst_resp", 64'(write_resp), 64'(2'b01));

    $display("[TB] randomized transactions");
    for (int i = 0; i < 24; i++) begin
      cnt = $urandom_range(0, 2);
      dw = (cnt != 1);
      dr = (cnt != 0);
      cfg_aw_delay = $urandom_range(0, 3); cfg_w_delay = $urandom_range(0, 3);
      cfg_b_delay = $urandom_range(0, 3); cfg_ar_delay = $urandom_range(0, 3);
      cfg_r_delay = $urandom_range(0, 3);
      cfg_bresp = 2'($urandom_range(0, 3)); cfg_rresp = 2'($urandom_range(0, 3));
      cfg_rdata = $urandom;
      ea = $urandom & 32'hFFFF_FFFC; ed = $urandom; es = 4'($urandom_range(0, 15));
      ra = $urandom & 32'hFFFF_FFFC;
      aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n; ar0 = ar_hs_n; r0 = r_hs_n;
      apply_stimulus(dw, dr, ea, ed, es, ra);
      wait_done(dw, dr, wl, rl, wc, rc, bb);
      if (dw) begin
        check_output("rnd_w_latency", 64'(wl), 64'((cfg_aw_delay > cfg_w_delay ? cfg_aw_delay : cfg_w_delay) + cfg_b_delay + 4));
        check_output("rnd_w_pulses", 64'(wc), 64'(1));
        check_output("rnd_w_hs", 64'({aw_hs_n - aw0, w_hs_n - w0, b_hs_n - b0}), 64'({32'd1, 32'd1, 32'd1}) & 64'hFFFF_FFFF_FFFF_FFFF);
        check_output("rnd_awaddr", 64'(last_awaddr), 64'(ea));
        check_output("rnd_wdata", 64'({last_wdata, last_wstrb}), 64'({ed, es}));
        check_output("rnd_wresp", 64'(write_resp), 64'(cfg_bresp));
      end else begin
        check_output("rnd_no_w_hs", 64'(aw_hs_n - aw0), 64'(0));
      end
      if (dr) begin
        check_output("rnd_r_latency", 64'(rl), 64'(cfg_ar_delay + cfg_r_delay + 4));
        check_output("rnd_r_pulses", 64'(rc), 64'(1));
        check_output("rnd_r_hs", 64'({ar_hs_n - ar0, r_hs_n - r0}), 64'({32'd1, 32'd1}));
        check_output("rnd_araddr", 64'(last_araddr), 64'(ra));
        check_output("rnd_rdata", 64'({read_data, read_resp}), 64'({cfg_rdata, cfg_rresp}));
      end else begin
        check_output("rnd_no_r_hs", 64'(ar_hs_n - ar0), 64'(0));
      end
      check_output("rnd_busy_at_done", 64'(bb), 64'(0));
    end

    check_output("payload_stable_while_valid", 64'(stab_err), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
- Initiator end of the AXI4-Lite link; drives `axi4_lite_slave` (or any compliant slave).
- Converts single-cycle user command pulses into complete AXI4-Lite write and read transactions.
- Write and read engines are independent: one outstanding write and one outstanding read may be in flight at the same time.
- Sits between local control logic (register sequencer, CPU bridge) and the bus.

Parameters:
- ADDR_WIDTH, 32, address width of AW/AR channels and user address inputs.
- DATA_WIDTH, 32, data width of W/R channels; must be 32 or 64; strobe width is DATA_WIDTH/8.

Ports:
- iCLK  in  1  system clock; all logic on rising edge.
- iRST  in  1  asynchronous active-low reset.
- m_AWVALID out 1 / m_AWPROT out 3 / m_AWADDR out ADDR_WIDTH / m_AWREADY in 1  write address channel.
- m_WVALID out 1 / m_WDATA out DATA_WIDTH / m_WSTRB out DATA_WIDTH/8 / m_WREADY in 1  write data channel.
- m_BVALID in 1 / m_BRESP in 2 / m_BREADY out 1  write response channel.
- m_ARVALID out 1 / m_ARPROT out 3 / m_ARADDR out ADDR_WIDTH / m_ARREADY in 1  read address channel.
- m_RVALID in 1 / m_RDATA in DATA_WIDTH / m_RRESP in 2 / m_RREADY out 1  read data channel.
- write_start in 1 / write_addr in ADDR_WIDTH / write_data in DATA_WIDTH / write_strb in DATA_WIDTH/8  user write command.
- write_busy out 1 / write_done out 1 / write_resp out 2  user write status.
- read_start in 1 / read_addr in ADDR_WIDTH  user read command.
- read_busy out 1 / read_done out 1 / read_data out DATA_WIDTH / read_resp out 2  user read status.

Behaviour:
- Reset (iRST=0, asynchronous):
  - all VALID/READY outputs, done and busy flags, resp, read_data, bus address/data/strb: 0.
  - both FSMs to IDLE.
- m_AWPROT and m_ARPROT are tied to 3'b000.
- All bus outputs are registered. VALID, once raised, stays high and its payload stays stable until the matching handshake (VALID & READY at a rising edge).

Write FSM: W_IDLE, W_ADDR, W_RESP, W_DONE.
- W_IDLE, write_start=1 at edge N:
  - latch write_addr/write_data/write_strb;
  - m_AWVALID=m_WVALID=1 from N+1;
  - write_busy=1.
- W_ADDR:
  - separate aw_done and w_done flags;
  - each VALID drops the cycle after its own handshake;
  - AW and W may complete in the same or different cycles, in either order;
  - when both are complete, go to W_RESP with m_BREADY=1.
- W_RESP:
  - on m_BVALID & m_BREADY: capture m_BRESP into write_resp; m_BREADY=0; go to W_DONE.
- W_DONE:
  - write_done=1 for exactly one cycle; write_busy=0 in the same cycle; return to W_IDLE.
- Best-case latency: write_start at N → write_done high in cycle N+4 (AW/W accepted at N+1, B at N+2).
- write_resp holds its value until the next B handshake.

Read FSM: R_IDLE, R_ADDR, R_DATA, R_DONE.
- R_IDLE, read_start=1: latch read_addr; m_ARVALID=1 next cycle; read_busy=1.
- R_ADDR: on AR handshake, m_ARVALID=0, m_RREADY=1, go to R_DATA.
- R_DATA: on m_RVALID & m_RREADY, capture m_RDATA and m_RRESP; m_RREADY=0; go to R_DONE.
- R_DONE: read_done=1 for one cycle; read_busy=0; return to R_IDLE.
- read_data and read_resp hold until the next R handshake.

Boundary conditions:
- start while busy (FSM not IDLE): ignored; no queueing. The user must wait for done.
- write_start and read_start in the same cycle: both accepted; engines run concurrently.
- READY held high before VALID is legal; the handshake completes on the first cycle VALID is high.
- BVALID/RVALID arriving before READY is raised: held by the slave; accepted once READY rises.
- SLVERR/DECERR responses: passed through unchanged; done still pulses; no retry.
- Reset mid-transaction: immediate return to IDLE with all outputs at reset values. No partial done pulse.

Test Plan:
- Write, slave ready throughout: write_start, addr 0x10, data 0xDEADBEEF, strb 0xF → AWADDR=0x10 and WDATA=0xDEADBEEF each accepted once; write_done pulses one cycle; write_resp=2'b00.
- Skewed write: AWREADY delayed 3 cycles, WREADY immediate → WVALID drops after 1 cycle, AWVALID stays high 4 cycles; exactly one B handshake; write_done once.
- Read: read_start, addr 0x20, slave returns 0xCAFEF00D with RRESP=2'b10 after 2 wait cycles → read_data=0xCAFEF00D; read_resp=2'b10; read_done single pulse.
- Concurrent write to 0x04 and read from 0x08 started in the same cycle → both done pulses occur; second write_start issued while write_busy=1 is ignored (exactly one AW handshake).
- Reset asserted while in W_RESP with BVALID low → all VALID/READY outputs 0 immediately; no write_done; a new write after reset release completes normally.
